// File: rtl/pp_row_scheduler.sv
// rtl/pp_row_scheduler.sv - row-burst sequencer from preprocess output FIFO into the Gaussian stage
module pp_row_scheduler #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int FIFO_DEPTH = 512,
  parameter int CW         = 9,
  parameter int RW         = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_enable,
  input  logic          i_mode_req,
  output logic          o_mode,
  input  logic          i_wr,
  output logic          o_rd,
  input  logic          i_ds_ready,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_sof,
  output logic          o_eol,
  output logic          o_eof,
  output logic [CW+1:0] o_occ,
  output logic          o_busy,
  output logic          o_overflow
);

  localparam int OW = CW + 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(FIFO_DEPTH);
  localparam logic [OW-1:0] OCC_ROW  = OW'(IMG_WIDTH);

  typedef enum logic [1:0] {
    WAIT_ROW = 2'd0,
    BURST    = 2'd1,
    ROW_END  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [OW-1:0] occ;

  // Reads follow downstream readiness directly so a stall never loses or repeats a pixel.
  assign o_busy = (state == BURST);
  assign o_rd   = (state == BURST) && i_ds_ready;
  assign o_col  = o_rd ? col : col_q;
  assign o_row  = o_rd ? row : row_q;
  assign o_sof  = o_rd && (col == '0) && (row == '0);
  assign o_eol  = o_rd && (col == COL_LAST);
  assign o_eof  = o_rd && (col == COL_LAST) && (row == ROW_LAST);
  assign o_occ  = occ;

  // Row sequencer: wait for a buffered row, burst it out, then advance row and latch mode at frame end.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= WAIT_ROW;
      col    <= '0;
      row    <= '0;
      col_q  <= '0;
      row_q  <= '0;
      o_mode <= 1'b0;
    end else begin
      case (state)
        WAIT_ROW: begin
          if (i_enable && (occ >= OCC_ROW)) begin
            state <= BURST;
          end
        end
        BURST: begin
          if (o_rd) begin
            col_q <= col;
            row_q <= row;
            if (col == COL_LAST) begin
              col   <= '0;
              state <= ROW_END;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        ROW_END: begin
          if (row == ROW_LAST) begin
            row    <= '0;
            o_mode <= i_mode_req;
          end else begin
            row <= row + 1'b1;
          end
          state <= WAIT_ROW;
        end
        default: state <= WAIT_ROW;
      endcase
    end
  end

  // Occupancy tracker; a write into a full FIFO saturates the count and latches overflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      occ        <= '0;
      o_overflow <= 1'b0;
    end else begin
      case ({i_wr, o_rd})
        2'b10: begin
          if (occ == OCC_FULL) begin
            o_overflow <= 1'b1;
          end else begin
            occ <= occ + 1'b1;
          end
        end
        2'b01: begin
          if (occ != '0) begin
            occ <= occ - 1'b1;
          end
        end
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_row_scheduler.sv
// tb/tb_pp_row_scheduler.sv - directed vector bench for pp_row_scheduler
module tb_pp_row_scheduler;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int D  = 8;
  localparam int CW = 2;
  localparam int RW = 1;

  logic          i_clk;
  logic          i_rst;
  logic          i_enable;
  logic          i_mode_req;
  logic          o_mode;
  logic          i_wr;
  logic          o_rd;
  logic          i_ds_ready;
  logic [CW-1:0] o_col;
  logic [RW-1:0] o_row;
  logic          o_sof;
  logic          o_eol;
  logic          o_eof;
  logic [CW+1:0] o_occ;
  logic          o_busy;
  logic          o_overflow;

  pp_row_scheduler #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .FIFO_DEPTH(D),
    .CW        (CW),
    .RW        (RW)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_enable  (i_enable),
    .i_mode_req(i_mode_req),
    .o_mode    (o_mode),
    .i_wr      (i_wr),
    .o_rd      (o_rd),
    .i_ds_ready(i_ds_ready),
    .o_col     (o_col),
    .o_row     (o_row),
    .o_sof     (o_sof),
    .o_eol     (o_eol),
    .o_eof     (o_eof),
    .o_occ     (o_occ),
    .o_busy    (o_busy),
    .o_overflow(o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    bit wr, en, rdy, mq;
    bit rd;
    int col, row;
    bit sof, eol, eof;
    int occ;
    bit busy, mode, ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_tests;
  int   n_fail;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit wr, en, rdy, mq, rd, input int col, row,
                     input bit sof, eol, eof, input int occ, input bit busy, mode, ovf);
    vec_t v;
    v.wr = wr; v.en = en; v.rdy = rdy; v.mq = mq;
    v.rd = rd; v.col = col; v.row = row;
    v.sof = sof; v.eol = eol; v.eof = eof;
    v.occ = occ; v.busy = busy; v.mode = mode; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    i_rst      = 1'b1;
    i_enable   = 1'b0;
    i_mode_req = 1'b0;
    i_wr       = 1'b0;
    i_ds_ready = 1'b1;

    //   wr en rdy mq rd col row sof eol eof occ busy mode ovf
    // full row
    add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0);
    add(0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 4, 1, 0, 0);
    add(0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 3, 1, 0, 0);
    add(0, 1, 1, 1, 1, 2, 0, 0, 0, 0, 2, 1, 0, 0);
    add(0, 1, 1, 1, 1, 3, 0, 0, 1, 0, 1, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // partial row holds off, fourth write triggers
    add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0);
    // row 1 with 2-cycle downstream stall after 2nd read, ends frame
    add(0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 4, 1, 0, 0);
    add(0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 3, 1, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
    add(0, 1, 1, 1, 1, 2, 1, 0, 0, 0, 2, 1, 0, 0);
    add(0, 1, 1, 1, 1, 3, 1, 0, 1, 1, 1, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    // new frame: row wraps to 0, same-cycle write+read holds occupancy
    add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0);
    add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 4, 0, 1, 0);
    add(0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 4, 1, 1, 0);
    add(1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 3, 1, 1, 0);
    add(0, 1, 1, 1, 1, 2, 0, 0, 0, 0, 3, 1, 1, 0);
    add(0, 1, 1, 1, 1, 3, 0, 0, 1, 0, 2, 1, 1, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);

    // reset state
    @(negedge i_clk);
    #1;
    chk("rst_rd", int'(o_rd), 0);
    chk("rst_occ", int'(o_occ), 0);
    chk("rst_mode", int'(o_mode), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_ovf", int'(o_overflow), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);

    foreach (vecs[i]) begin
      @(negedge i_clk);
      i_wr       = vecs[i].wr;
      i_enable   = vecs[i].en;
      i_ds_ready = vecs[i].rdy;
      i_mode_req = vecs[i].mq;
      #1;
      chk($sformatf("v%0d_rd", i), int'(o_rd), int'(vecs[i].rd));
      chk($sformatf("v%0d_occ", i), int'(o_occ), vecs[i].occ);
      chk($sformatf("v%0d_busy", i), int'(o_busy), int'(vecs[i].busy));
      chk($sformatf("v%0d_mode", i), int'(o_mode), int'(vecs[i].mode));
      chk($sformatf("v%0d_ovf", i), int'(o_overflow), int'(vecs[i].ovf));
      chk($sformatf("v%0d_sof", i), int'(o_sof), int'(vecs[i].sof));
      chk($sformatf("v%0d_eol", i), int'(o_eol), int'(vecs[i].eol));
      chk($sformatf("v%0d_eof", i), int'(o_eof), int'(vecs[i].eof));
      if (vecs[i].rd) begin
        chk($sformatf("v%0d_col", i), int'(o_col), vecs[i].col);
        chk($sformatf("v%0d_row", i), int'(o_row), vecs[i].row);
      end
    end

    // overflow with scheduler disabled
    @(negedge i_clk);
    i_rst = 1'b1;
    i_wr = 1'b0; i_enable = 1'b0; i_ds_ready = 1'b1; i_mode_req = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    i_wr  = 1'b1;
    repeat (8) @(posedge i_clk);
    @(negedge i_clk);
    #1;
    chk("ovf_occ8", int'(o_occ), 8);
    chk("ovf_pre", int'(o_overflow), 0);
    chk("ovf_no_rd", int'(o_rd), 0);
    @(negedge i_clk);
    #1;
    chk("ovf_set", int'(o_overflow), 1);
    chk("ovf_sat", int'(o_occ), 8);
    i_wr = 1'b0; i_enable = 1'b1;
    @(negedge i_clk);
    i_wr = 1'b1;
    #1;
    chk("sim_rd0", int'(o_rd), 1);
    chk("sim_col0", int'(o_col), 0);
    @(negedge i_clk);
    #1;
    chk("sim_occ_hold", int'(o_occ), 8);
    chk("sim_col1", int'(o_col), 1);
    chk("ovf_sticky", int'(o_overflow), 1);
    i_wr = 1'b0;
    @(negedge i_clk);
    #1;
    chk("sim_occ_dec", int'(o_occ), 7);
    @(negedge i_clk);
    #1;
    chk("r0_eol", int'(o_eol), 1);
    @(negedge i_clk);
    #1;
    chk("r0_rowend_rd", int'(o_rd), 0);
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    chk("r1_rd0", int'(o_rd), 1);
    chk("r1_row", int'(o_row), 1);
    chk("r1_nosof", int'(o_sof), 0);
    @(negedge i_clk);
    #1;
    chk("r1_col1", int'(o_col), 1);

    // reset mid-burst after the 2nd read
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk("mrst_rd", int'(o_rd), 0);
    chk("mrst_busy", int'(o_busy), 0);
    chk("mrst_col", int'(o_col), 0);
    chk("mrst_row", int'(o_row), 0);
    chk("mrst_occ", int'(o_occ), 0);
    chk("mrst_ovf", int'(o_overflow), 0);
    chk("mrst_mode", int'(o_mode), 0);
    chk("mrst_marks", int'({o_sof, o_eol, o_eof}), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    i_wr  = 1'b1;
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    i_wr = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        #1;
        if (o_rd) begin
          seen = 1'b1;
          chk("post_col", int'(o_col), 0);
          chk("post_row", int'(o_row), 0);
          chk("post_sof", int'(o_sof), 1);
        end else begin
          @(negedge i_clk);
        end
      end
      chk("post_burst_seen", int'(seen), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
